sequence_checker: RTL

//  AXI-Stream slave that sinks the power-of-3 stream from the stream generator and checks it word by word.

---
 rtl/sequence_checker.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/sequence_checker.sv
// -----------------------------------------------------------------------------
// sequence_checker
//
// AXI-Stream sink that checks a power-of-3 stream word by word. Each accepted
// word must equal the previously accepted word times 3, truncated to DATA_SIZE
// bits. The first word after reset or clear must equal START_VALUE. Matching
// words and mismatching words are counted in saturating counters, and any
// mismatch sets a sticky error flag. After a mismatch the checker resyncs to
// the received data, so only the broken link in the chain is counted.
//
// Optional build macro:
//   ERR_HALT_EN  when defined, a mismatch parks the FSM in HALT and drops
//                tready until clear or reset. When undefined there is no
//                HALT state and the checker keeps running.
//
// Parameters:
//   DATA_SIZE    tdata width (tstrb is DATA_SIZE/8 bits)
//   CNT_WIDTH    width of word_count / err_count
//   START_VALUE  expected value of the first word after reset or clear
//
// Ports:
//   s00_axis_aclk    clock, rising edge
//   s00_axis_areset  synchronous active-high reset
//   s00_axis_enable  permits word acceptance (tready follows it one cycle later)
//   s00_axis_tdata   stream data
//   s00_axis_tstrb   byte strobes, ignored
//   s00_axis_tvalid  stream valid
//   s00_axis_tlast   stream last, mirrored to rx_last only
//   s00_axis_tready  registered ready
//   clear            synchronous clear of counters, flag, expected value, FSM
//   rx_data          last accepted word
//   rx_last          tlast of the last accepted word
//   rx_valid         one-cycle pulse the cycle after each handshake
//   word_count       matching words, saturating
//   err_count        mismatching words, saturating
//   err_flag         sticky mismatch flag
//   running          high while the FSM is in RUN
// -----------------------------------------------------------------------------
module sequence_checker #(
  parameter int DATA_SIZE   = 32,
  parameter int CNT_WIDTH   = 16,
  parameter int START_VALUE = 3
) (
  input  logic                   s00_axis_aclk,
  input  logic                   s00_axis_areset,
  input  logic                   s00_axis_enable,
  input  logic [DATA_SIZE-1:0]   s00_axis_tdata,
  input  logic [DATA_SIZE/8-1:0] s00_axis_tstrb,
  input  logic                   s00_axis_tvalid,
  input  logic                   s00_axis_tlast,
  output logic                   s00_axis_tready,
  input  logic                   clear,
  output logic [DATA_SIZE-1:0]   rx_data,
  output logic                   rx_last,
  output logic                   rx_valid,
  output logic [CNT_WIDTH-1:0]   word_count,
  output logic [CNT_WIDTH-1:0]   err_count,
  output logic                   err_flag,
  output logic                   running
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
`ifdef ERR_HALT_EN
    ,
    HALT = 2'd2
`endif
  } state_t;

  // Multiply by 3 as d + 2d, keeping only the low DATA_SIZE bits so the
  // checker wraps exactly like the generator does.
  function automatic logic [DATA_SIZE-1:0] times3(input logic [DATA_SIZE-1:0] d);
    logic [DATA_SIZE+1:0] p;
    p = {2'b00, d} + {1'b0, d, 1'b0};
    return p[DATA_SIZE-1:0];
  endfunction

  // Saturating increment: an all-ones counter holds.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  state_t                 state_p1;
  state_t                 state_nxt;
  logic [DATA_SIZE-1:0]   expected_p1;
  logic                   tready_p1;
  logic                   tready_nxt;
  logic [DATA_SIZE-1:0]   rx_data_p1;
  logic                   rx_last_p1;
  logic                   vld_p1;
  logic [CNT_WIDTH-1:0]   word_cnt_p1;
  logic [CNT_WIDTH-1:0]   err_cnt_p1;
  logic                   err_flag_p1;
  logic                   hs;
  logic                   mismatch;
  logic                   unused_tstrb;

  assign unused_tstrb = ^s00_axis_tstrb;

  assign hs       = s00_axis_tvalid && tready_p1;
  assign mismatch = (s00_axis_tdata != expected_p1);

  always_comb begin
    state_nxt = state_p1;
    if (clear) begin
      state_nxt = IDLE;
    end else if (hs) begin
`ifdef ERR_HALT_EN
      state_nxt = mismatch ? HALT : RUN;
`else
      state_nxt = RUN;
`endif
    end
  end

  // Ready is registered, so it reflects enable (and HALT) one cycle late.
`ifdef ERR_HALT_EN
  assign tready_nxt = s00_axis_enable && (state_nxt != HALT);
`else
  assign tready_nxt = s00_axis_enable;
`endif

  // ---- stage p1: handshake capture, compare and counter update ----
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state_p1    <= IDLE;
      tready_p1   <= 1'b0;
      expected_p1 <= DATA_SIZE'(START_VALUE);
      rx_data_p1  <= '0;
      rx_last_p1  <= 1'b0;
      vld_p1      <= 1'b0;
      word_cnt_p1 <= '0;
      err_cnt_p1  <= '0;
      err_flag_p1 <= 1'b0;
    end else begin
      state_p1  <= state_nxt;
      tready_p1 <= tready_nxt;
      if (clear) begin
        // A handshake coinciding with clear is dropped; rx_data/rx_last hold.
        expected_p1 <= DATA_SIZE'(START_VALUE);
        vld_p1      <= 1'b0;
        word_cnt_p1 <= '0;
        err_cnt_p1  <= '0;
        err_flag_p1 <= 1'b0;
      end else if (hs) begin
        rx_data_p1  <= s00_axis_tdata;
        rx_last_p1  <= s00_axis_tlast;
        vld_p1      <= 1'b1;
        if (mismatch) begin
          err_cnt_p1  <= sat_inc(err_cnt_p1);
          err_flag_p1 <= 1'b1;
        end else begin
          word_cnt_p1 <= sat_inc(word_cnt_p1);
        end
        // Resync to what was received, not to what was expected.
        expected_p1 <= times3(s00_axis_tdata);
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign s00_axis_tready = tready_p1;
  assign rx_data         = rx_data_p1;
  assign rx_last         = rx_last_p1;
  assign rx_valid        = vld_p1;
  assign word_count      = word_cnt_p1;
  assign err_count       = err_cnt_p1;
  assign err_flag        = err_flag_p1;
  assign running         = (state_p1 == RUN);

endmodule
